// File: rtl/race_pkg.sv
// Shared types and helpers for the dice-race turn sequencer: state encoding,
// colour-to-steps mapping and width helpers for the position/player fields.
package race_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_ROLL  = 3'd2,
        S_MOVE  = 3'd3,
        S_EVENT = 3'd4,
        S_NEXT  = 3'd5,
        S_WIN   = 3'd6
    } race_state_t;

    localparam int STEP_W = 3;

    function automatic logic [STEP_W-1:0] steps_from_colour(input logic [1:0] colour);
        return {1'b0, colour} + 3'd1;
    endfunction

    function automatic int pos_width(input int board_len);
        return $clog2(board_len);
    endfunction

    function automatic int pid_width(input int num_players);
        return (num_players > 2) ? $clog2(num_players) : 1;
    endfunction

endpackage

// File: rtl/race_tick_timer.sv
// Terminal-count tick counter: counts 0..TICKS-1 while enabled and pulses done
// on the last count, wrapping to 0. clear holds it at 0.
module race_tick_timer #(
    parameter int TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] count;

    assign done = enable && !clear && (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // in the design samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= done ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/race_turn_engine.sv
// N-player dice-race turn sequencer with animated stepping and event tiles.
// Define RACE_BOUNCE_BACK_EN to require an exact goal hit (overshoot bounces back).
module race_turn_engine
    import race_pkg::*;
#(
    parameter int                   NUM_PLAYERS   = 2,
    parameter int                   BOARD_LEN     = 16,
    parameter int                   MOVE_TICKS    = 25_000_000,
    parameter logic [BOARD_LEN-1:0] EVENT_MASK    = BOARD_LEN'(16'h0410),
    parameter int                   EVENT_BACK    = 2,
    parameter int                   EVENT_TIMEOUT = 250_000_000,
    localparam int                  POS_W         = pos_width(BOARD_LEN),
    localparam int                  PID_W         = pid_width(NUM_PLAYERS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         dice_valid,
    input  logic [1:0]                   dice_value,
    input  logic                         white_stable,
    input  logic                         event_ack,
    output logic [NUM_PLAYERS*POS_W-1:0] pos_flat,
    output logic [PID_W-1:0]             turn,
    output logic                         pos_valid,
    output logic                         turn_done,
    output logic                         winner_valid,
    output logic [PID_W-1:0]             winner_id,
    output logic                         event_active,
    output logic [2:0]                   state_dbg
);

    localparam logic [POS_W-1:0] GOAL     = POS_W'(BOARD_LEN - 1);
    localparam logic [POS_W-1:0] BACK     = POS_W'(EVENT_BACK);
    localparam logic [PID_W-1:0] LAST_PID = PID_W'(NUM_PLAYERS - 1);

    race_state_t       state, state_next;
    logic [POS_W-1:0]  pos_q [NUM_PLAYERS];
    logic [PID_W-1:0]  turn_q;
    logic              armed;
    logic [STEP_W-1:0] steps_left;

    logic              move_run, event_run;
    logic              move_done, event_timeout;
    logic [POS_W-1:0]  cur_pos, step_pos, back_pos;
    logic              last_step, at_goal, win_hit;
    logic              new_game, arm_set, roll_latch, step_en, back_en, advance;
`ifdef RACE_BOUNCE_BACK_EN
    logic              reverse, reverse_set;
`endif

    assign move_run  = (state == S_MOVE);
    assign event_run = (state == S_EVENT);

    race_tick_timer #(.TICKS(MOVE_TICKS)) u_move_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!move_run),
        .enable (move_run),
        .done   (move_done)
    );

    race_tick_timer #(.TICKS(EVENT_TIMEOUT)) u_event_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!event_run),
        .enable (event_run),
        .done   (event_timeout)
    );

    always_comb begin
        cur_pos   = pos_q[turn_q];
`ifdef RACE_BOUNCE_BACK_EN
        step_pos    = reverse ? cur_pos - POS_W'(1) : cur_pos + POS_W'(1);
        last_step   = (steps_left == STEP_W'(1));
        at_goal     = (step_pos == GOAL);
        win_hit     = at_goal && last_step;
        reverse_set = at_goal && !last_step;
`else
        step_pos  = cur_pos + POS_W'(1);
        last_step = (steps_left == STEP_W'(1));
        at_goal   = (step_pos == GOAL);
        win_hit   = at_goal;
`endif
        back_pos  = (cur_pos > BACK) ? cur_pos - BACK : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        new_game   = 1'b0;
        arm_set    = 1'b0;
        roll_latch = 1'b0;
        step_en    = 1'b0;
        back_en    = 1'b0;
        advance    = 1'b0;
        unique case (state)
            S_IDLE, S_WIN: begin
                if (start) begin
                    new_game   = 1'b1;
                    state_next = S_ARM;
                end
            end
            S_ARM: begin
                if (armed) begin
                    state_next = S_ROLL;
                end else if (white_stable) begin
                    arm_set = 1'b1;
                end
            end
            S_ROLL: begin
                if (dice_valid) begin
                    roll_latch = 1'b1;
                    state_next = S_MOVE;
                end
            end
            S_MOVE: begin
                if (move_done) begin
                    step_en = 1'b1;
                    if (win_hit) begin
                        state_next = S_WIN;
                    end else if (last_step) begin
                        state_next = EVENT_MASK[step_pos] ? S_EVENT : S_NEXT;
                    end
                end
            end
            S_EVENT: begin
                if (event_ack || event_timeout) begin
                    back_en    = 1'b1;
                    state_next = S_NEXT;
                end
            end
            S_NEXT: begin
                advance    = 1'b1;
                state_next = S_ARM;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: the position bank is a handful of flops that must read 0 after
    // reset, so it is reset like any other register rather than left as memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NUM_PLAYERS; p++) pos_q[p] <= '0;
            turn_q     <= '0;
            armed      <= 1'b0;
            steps_left <= '0;
            pos_valid  <= 1'b0;
            turn_done  <= 1'b0;
        end else begin
            pos_valid <= step_en || back_en;
            turn_done <= advance;
            if (new_game) begin
                for (int p = 0; p < NUM_PLAYERS; p++) pos_q[p] <= '0;
                turn_q <= '0;
                armed  <= 1'b0;
            end
            if (arm_set) armed <= 1'b1;
            if (roll_latch) steps_left <= steps_from_colour(dice_value);
            if (step_en) begin
                pos_q[turn_q] <= step_pos;
                steps_left    <= steps_left - STEP_W'(1);
            end
            if (back_en) pos_q[turn_q] <= back_pos;
            if (advance) begin
                turn_q <= (turn_q == LAST_PID) ? '0 : turn_q + PID_W'(1);
                armed  <= 1'b0;
            end
        end
    end

`ifdef RACE_BOUNCE_BACK_EN
    // Direction restarts forward on every roll; it flips once the goal is passed through.
    always_ff @(posedge clk) begin
        if (reset || roll_latch) begin
            reverse <= 1'b0;
        end else if (step_en && reverse_set) begin
            reverse <= 1'b1;
        end
    end
`endif

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pos
        assign pos_flat[p*POS_W +: POS_W] = pos_q[p];
    end

    assign turn         = turn_q;
    assign event_active = event_run;
    assign winner_valid = (state == S_WIN);
    assign winner_id    = winner_valid ? turn_q : '0;
    assign state_dbg    = state;

endmodule

// File: tb/tb_race_turn_engine.sv
// Self-checking bench for race_turn_engine: directed scenarios plus random turns,
// all compared against a rule-level model of the race held in this file.
module tb_race_turn_engine;

    localparam int NP     = 3;
    localparam int BL     = 16;
    localparam int MT     = 4;
    localparam int ET     = 20;
    localparam int EVB    = 2;
    localparam int GOAL   = BL - 1;
    localparam int POS_W  = 4;
    localparam int PID_W  = 2;
    localparam logic [15:0] EV_MASK = 16'h0010;

    logic              clk = 1'b0;
    logic              reset, start, dice_valid, white_stable, event_ack;
    logic [1:0]        dice_value;
    logic [NP*POS_W-1:0] pos_flat;
    logic [PID_W-1:0]  turn, winner_id;
    logic              pos_valid, turn_done, winner_valid, event_active;
    logic [2:0]        state_dbg;

    race_turn_engine #(
        .NUM_PLAYERS  (NP),
        .BOARD_LEN    (BL),
        .MOVE_TICKS   (MT),
        .EVENT_MASK   (EV_MASK),
        .EVENT_BACK   (EVB),
        .EVENT_TIMEOUT(ET)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dice_valid  (dice_valid),
        .dice_value  (dice_value),
        .white_stable(white_stable),
        .event_ack   (event_ack),
        .pos_flat    (pos_flat),
        .turn        (turn),
        .pos_valid   (pos_valid),
        .turn_done   (turn_done),
        .winner_valid(winner_valid),
        .winner_id   (winner_id),
        .event_active(event_active),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: player positions, whose turn, and whether the game is won.
    int m_pos [NP];
    int m_turn;
    bit m_win;
    int exp_traj[$];
    int move_len;
    bit exp_win, exp_evt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dut_pos(input int p);
        return int'(pos_flat[p*POS_W +: POS_W]);
    endfunction

    task automatic model_clear();
        for (int p = 0; p < NP; p++) m_pos[p] = 0;
        m_turn = 0;
        m_win  = 0;
    endtask

    // Walk the tiles one at a time from the game rules, recording every tile shown.
    task automatic model_turn(input int p0, input int steps);
        int p, dir;
        p = p0;
        dir = 1;
        exp_traj.delete();
        exp_win = 0;
        for (int k = 0; k < steps && !exp_win; k++) begin
            p += dir;
            exp_traj.push_back(p);
            if (p == GOAL) begin
`ifdef RACE_BOUNCE_BACK_EN
                if (k == steps - 1) exp_win = 1;
                else dir = -1;
`else
                exp_win = 1;
`endif
            end
        end
        move_len = exp_traj.size();
        exp_evt  = !exp_win && EV_MASK[p];
        if (exp_evt) exp_traj.push_back((p >= EVB) ? p - EVB : 0);
    endtask

    task automatic check_all_pos(input string tag);
        for (int p = 0; p < NP; p++) check(tag, dut_pos(p), m_pos[p]);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        start = 1'b0; dice_valid = 1'b0; dice_value = 2'd0;
        white_stable = 1'b0; event_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_clear();
        check("start_state", state_dbg, 1);
        check("start_turn", turn, 0);
        check_all_pos("start_pos");
    endtask

    // One complete turn for the current player; noisy adds ignored stray inputs.
    task automatic run_turn(input int value, input int ack_delay, input bit noisy);
        int cur, pv_idx, last_pv, evt_cycles;
        bit done_seen, win_seen, in_roll;
        cur = m_turn;
        model_turn(m_pos[cur], value + 1);
        if (noisy) begin
            dice_valid = 1'b1;
            dice_value = 2'($urandom);
            @(negedge clk);
            dice_valid = 1'b0;
            @(negedge clk);
            check("arm_waits_white", state_dbg, 1);
            check_all_pos("arm_noise_pos");
        end
        white_stable = 1'b1;
        dice_valid   = noisy;
        dice_value   = 2'($urandom);
        in_roll = 0;
        for (int c = 0; c < 10 && !in_roll; c++) begin
            @(negedge clk);
            dice_valid = 1'b0;
            in_roll = (state_dbg == 3'd2);
        end
        check("roll_reached", in_roll, 1);
        dice_valid = 1'b1;
        dice_value = 2'(value);
        @(negedge clk);
        dice_valid = 1'b0;
        check("enter_move", state_dbg, 3);

        pv_idx = 0; last_pv = 0; evt_cycles = 0; done_seen = 0; win_seen = 0;
        for (int c = 0; c < 300 && !done_seen; c++) begin
            @(negedge clk);
            dice_valid = 1'b0; start = 1'b0; event_ack = 1'b0;
            if (pos_valid) begin
                if (pv_idx < exp_traj.size()) check("step_pos", dut_pos(cur), exp_traj[pv_idx]);
                if (pv_idx == 0) check("first_step_latency", c, MT - 1);
                else if (pv_idx < move_len) check("step_spacing", c - last_pv, MT);
                last_pv = c;
                pv_idx++;
            end
            if (event_active) begin
                evt_cycles++;
                if (evt_cycles == ack_delay) event_ack = 1'b1;
            end
            if (winner_valid) begin
                check("winner_id", winner_id, cur);
                check("win_state", state_dbg, 6);
                win_seen  = 1;
                done_seen = 1;
            end else if (turn_done) begin
                done_seen = 1;
            end else if (noisy && state_dbg == 3'd3) begin
                dice_valid = ($urandom_range(0, 3) == 0);
                start      = ($urandom_range(0, 7) == 0);
                dice_value = 2'($urandom);
            end
        end
        dice_valid = 1'b0; start = 1'b0; event_ack = 1'b0;
        white_stable = 1'b0;
        check("turn_ended", done_seen, 1);
        check("pos_valid_count", pv_idx, exp_traj.size());
        check("win_outcome", win_seen, exp_win);
        check("event_seen", evt_cycles != 0, exp_evt);
        if (exp_evt) check("event_cycles", evt_cycles, (ack_delay < ET) ? ack_delay : ET);

        m_pos[cur] = exp_traj[exp_traj.size() - 1];
        if (exp_win) begin
            m_win = 1;
        end else begin
            m_turn = (m_turn + 1) % NP;
        end
        @(negedge clk);
        check("turn_after", turn, m_turn);
        check_all_pos("pos_after");
    endtask

    initial begin
        apply_reset();
        check("rst_pos", pos_flat, 0);
        check("rst_turn", turn, 0);
        check("rst_pos_valid", pos_valid, 0);
        check("rst_turn_done", turn_done, 0);
        check("rst_winner_valid", winner_valid, 0);
        check("rst_winner_id", winner_id, 0);
        check("rst_event_active", event_active, 0);
        check("rst_state", state_dbg, 0);

        // IDLE ignores everything but start.
        white_stable = 1'b1; dice_valid = 1'b1; event_ack = 1'b1;
        @(negedge clk);
        dice_valid = 1'b0; event_ack = 1'b0; white_stable = 1'b0;
        @(negedge clk);
        check("idle_holds", state_dbg, 0);
        do_start();

        // Player 0 rolls value 2: 1, 2, 3; then player 1 with stray inputs.
        run_turn(2, 5, 0);
        run_turn(0, 5, 1);

        // Fresh game: three single steps, then player 0 lands on the event tile and times out.
        apply_reset();
        do_start();
        run_turn(0, 5, 0);
        run_turn(0, 5, 0);
        run_turn(0, 5, 0);
        run_turn(2, 30, 0);

        // Drive player 0 to tile 14, then roll value 3 at the goal.
        for (int t = 0; t < 40 && !(m_turn == 0 && m_pos[0] == 14); t++) begin
            if (m_turn == 0) begin
                int need;
                need = 14 - m_pos[0];
                run_turn(((need > 4) ? 4 : need) - 1, $urandom_range(1, 30), 0);
            end else begin
                run_turn(0, $urandom_range(1, 30), 0);
            end
        end
        check("setup_at_14", m_pos[0], 14);
        run_turn(3, 5, 0);
        if (m_win) do_start();

        // Random turns with stray inputs, restarting whenever somebody wins.
        for (int t = 0; t < 60; t++) begin
            run_turn($urandom_range(0, 3), $urandom_range(1, 30), $urandom_range(0, 1) == 1);
            if (m_win) do_start();
        end

        // Reset in the middle of a move.
        white_stable = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_abort_roll", state_dbg, 2);
        dice_valid = 1'b1; dice_value = 2'd3;
        @(negedge clk);
        dice_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_pos", pos_flat, 0);
        check("abort_turn", turn, 0);
        check("abort_pos_valid", pos_valid, 0);
        check("abort_turn_done", turn_done, 0);
        check("abort_winner", winner_valid, 0);
        check("abort_event", event_active, 0);
        check("abort_state", state_dbg, 0);
        reset = 1'b0;
        white_stable = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
